// File: rtl/pingpong_mc_pkg.sv
// Shared state encodings and width helpers for the multi-channel ping-pong buffer.
// Pure declarations: no logic, no latency, no flow control.
package pingpong_mc_pkg;

  typedef enum logic [1:0] {
    WR_FILL   = 2'd0,
    WR_FULL   = 2'd1,
    WR_RESYNC = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_e;

  // A counter or index over n values needs at least one bit, even for n==1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_width(input int depth, input int num_ch);
    return clog2_min1(depth * num_ch);
  endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// One sample bank: single-port RAM with registered read (1-cycle latency) and write priority.
// No backpressure; the read register holds its value until the next read is issued.
module pp_bank_ram
  import pingpong_mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 20,
  localparam int AW = clog2_min1(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // Storage is never reset; only the read register is, so read-out is 0 after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pingpong_mc_buffer.sv
// Two-bank ping-pong buffer for channel-interleaved ADC samples; read-out is one word per 2 cycles
// over valid/ready, and input samples are dropped (frame-aligned) while both banks are full. Stats: PINGPONG_MC_STATS_EN.
module pingpong_mc_buffer
  import pingpong_mc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 10,
  parameter int NUM_CH = 2,
  localparam int N  = DEPTH * NUM_CH,
  localparam int AW = addr_width(DEPTH, NUM_CH),
  localparam int CW = clog2_min1(NUM_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    rd_ch_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             rd_last_o,
  output logic             buffer_ready_o,
  output logic             overflow_o,
  output logic             overflow_sticky_o,
  input  logic             clear_i
`ifdef PINGPONG_MC_STATS_EN
  ,
  output logic [15:0]      drop_count_o,
  output logic [15:0]      frame_count_o
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);

  wr_state_e        wr_state;
  rd_state_e        rd_state;
  logic             wr_bank;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [CW-1:0]    in_ch;
  logic [CW-1:0]    in_ch_nxt;
  logic [CW-1:0]    rd_ch;

  logic             wr_en;
  logic             bank_full;
  logic             rd_done;
  logic             rd_free;
  logic             swap;
  logic             drop;
  logic             rd_issue;
  logic [WIDTH-1:0] bank_q [2];

  // in_ch counts every valid sample, dropped or not, so channel alignment survives overflow.
  assign in_ch_nxt = !sample_valid_i     ? in_ch :
                     (in_ch == LAST_CH)  ? '0    : in_ch + 1'b1;

  assign wr_en     = (wr_state == WR_FILL) && sample_valid_i;
  assign bank_full = wr_en && (wr_addr == LAST_ADDR);
  assign drop      = sample_valid_i && (wr_state != WR_FILL);

  // The reader counts as free on the cycle of its final handshake, so a fill that
  // completes in that same cycle swaps immediately instead of stalling a cycle.
  assign rd_done  = (rd_state == RD_HOLD) && rd_ready_i && (rd_addr == LAST_ADDR);
  assign rd_free  = (rd_state == RD_IDLE) || rd_done;
  assign swap     = (bank_full || (wr_state == WR_FULL)) && rd_free;
  assign rd_issue = (rd_state == RD_FETCH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state          <= WR_FILL;
      wr_bank           <= 1'b0;
      wr_addr           <= '0;
      in_ch             <= '0;
      buffer_ready_o    <= 1'b0;
      overflow_o        <= 1'b0;
      overflow_sticky_o <= 1'b0;
    end else begin
      in_ch          <= in_ch_nxt;
      buffer_ready_o <= swap;
      overflow_o     <= drop;
      if (drop) begin
        overflow_sticky_o <= 1'b1;
      end else if (clear_i) begin
        overflow_sticky_o <= 1'b0;
      end
      if (swap) begin
        wr_bank <= ~wr_bank;
      end
      case (wr_state)
        WR_FILL: begin
          if (wr_en) begin
            wr_addr <= bank_full ? '0 : wr_addr + 1'b1;
            if (bank_full && !rd_free) begin
              wr_state <= WR_FULL;
            end
          end
        end
        WR_FULL: begin
          // Resume only on a frame boundary, judged by the channel of the next sample.
          if (rd_free) begin
            wr_state <= (in_ch_nxt == '0) ? WR_FILL : WR_RESYNC;
          end
        end
        WR_RESYNC: begin
          if (in_ch_nxt == '0) begin
            wr_state <= WR_FILL;
          end
        end
        default: wr_state <= WR_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state   <= RD_IDLE;
      rd_addr    <= '0;
      rd_ch      <= '0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
    end else if (swap) begin
      rd_state   <= RD_FETCH;
      rd_addr    <= '0;
      rd_ch      <= '0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
    end else begin
      case (rd_state)
        RD_FETCH: begin
          rd_state   <= RD_HOLD;
          rd_valid_o <= 1'b1;
          rd_last_o  <= (rd_addr == LAST_ADDR);
        end
        RD_HOLD: begin
          if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            if (rd_addr == LAST_ADDR) begin
              rd_state <= RD_IDLE;
            end else begin
              rd_state <= RD_FETCH;
              rd_addr  <= rd_addr + 1'b1;
              rd_ch    <= (rd_ch == LAST_CH) ? '0 : rd_ch + 1'b1;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign rd_ch_o = rd_ch;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_wr_bank;
    assign is_wr_bank = (wr_bank == 1'(b));

    pp_bank_ram #(
      .WIDTH (WIDTH),
      .WORDS (N)
    ) u_ram (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (wr_en && is_wr_bank),
      .re    (rd_issue && !is_wr_bank),
      .addr  (is_wr_bank ? wr_addr : rd_addr),
      .wdata (sample_i),
      .rdata (bank_q[b])
    );
  end

  // The read side always owns the bank that is not being filled.
  assign rd_data_o = wr_bank ? bank_q[0] : bank_q[1];

`ifdef PINGPONG_MC_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_count_o  <= '0;
      frame_count_o <= '0;
    end else begin
      if (clear_i) begin
        drop_count_o <= {15'd0, drop};
      end else if (drop && (drop_count_o != 16'hFFFF)) begin
        drop_count_o <= drop_count_o + 16'd1;
      end
      if (swap) begin
        frame_count_o <= frame_count_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_mc_buffer.sv
// Bench: directed scenarios plus random traffic, checked every cycle against a queue-level model.
module tb_pingpong_mc_buffer;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 2;
  localparam int N      = DEPTH * NUM_CH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] rd_data;
  logic [0:0]  rd_ch;
  logic        rd_valid, rd_last, buffer_ready, overflow, overflow_sticky;
`ifdef PINGPONG_MC_STATS_EN
  logic [15:0] drop_count, frame_count;
`endif

  always #5 clk = ~clk;

  pingpong_mc_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .sample_i          (sample),
    .sample_valid_i    (sample_valid),
    .rd_data_o         (rd_data),
    .rd_ch_o           (rd_ch),
    .rd_valid_o        (rd_valid),
    .rd_ready_i        (rd_ready),
    .rd_last_o         (rd_last),
    .buffer_ready_o    (buffer_ready),
    .overflow_o        (overflow),
    .overflow_sticky_o (overflow_sticky),
    .clear_i           (clear)
`ifdef PINGPONG_MC_STATS_EN
    ,
    .drop_count_o      (drop_count),
    .frame_count_o     (frame_count)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the bank being filled and the bank being drained are plain queues.
  logic [15:0] fill_q[$];
  logic [15:0] drain_q[$];
  int  rd_idx = 0;
  int  ch_cnt = 0;
  int  nxt_ch = 0;
  bit  busy = 0, showing = 0, blocked = 0, resync = 0;
  bit  free_now = 0, hs = 0;
  bit  m_swap = 0, m_drop = 0, m_sticky = 0;
  int  m_dcnt = 0, m_fcnt = 0, m_drop_total = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q.delete();
      drain_q.delete();
      rd_idx = 0; ch_cnt = 0; busy = 0; showing = 0; blocked = 0; resync = 0;
      m_swap = 0; m_drop = 0; m_sticky = 0; m_dcnt = 0; m_fcnt = 0;
    end else begin
      free_now = !busy || (showing && rd_ready && rd_idx == N - 1);
      hs       = showing && rd_ready;
      m_swap   = 0;
      m_drop   = 0;
      nxt_ch   = sample_valid ? (ch_cnt + 1) % NUM_CH : ch_cnt;
      if (!blocked && !resync) begin
        if (sample_valid) begin
          fill_q.push_back(sample);
          if (fill_q.size() == N) begin
            if (free_now) m_swap = 1;
            else blocked = 1;
          end
        end
      end else begin
        m_drop = sample_valid;
        if (blocked) begin
          if (free_now) begin
            m_swap  = 1;
            blocked = 0;
            resync  = (nxt_ch != 0);
          end
        end else if (nxt_ch == 0) begin
          resync = 0;
        end
      end
      ch_cnt = nxt_ch;
      if (hs) begin
        showing = 0;
        rd_idx++;
        if (rd_idx == N) busy = 0;
      end else if (busy && !showing) begin
        showing = 1;
      end
      if (m_swap) begin
        drain_q = fill_q;
        fill_q.delete();
        busy = 1; showing = 0; rd_idx = 0;
        m_fcnt = (m_fcnt + 1) % 65536;
      end
      if (m_drop) begin
        m_sticky = 1;
        m_drop_total++;
      end else if (clear) begin
        m_sticky = 0;
      end
      if (clear) m_dcnt = m_drop ? 1 : 0;
      else if (m_drop && m_dcnt < 65535) m_dcnt++;
    end
  end

  // Observed handshakes and pulse counts, plus the per-cycle model comparison.
  logic [15:0] log_d[$];
  logic        log_c[$];
  logic        log_l[$];
  int br_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (buffer_ready) br_cnt++;
      if (overflow) ov_cnt++;
      if (rd_valid && rd_ready) begin
        log_d.push_back(rd_data);
        log_c.push_back(rd_ch[0]);
        log_l.push_back(rd_last);
      end
      check("rd_valid", rd_valid, showing);
      check("rd_last", rd_last, showing && rd_idx == N - 1);
      check("buffer_ready", buffer_ready, m_swap);
      check("overflow", overflow, m_drop);
      check("overflow_sticky", overflow_sticky, m_sticky);
      if (showing) begin
        check("rd_data", rd_data, drain_q[rd_idx]);
        check("rd_ch", rd_ch, rd_idx % NUM_CH);
      end
`ifdef PINGPONG_MC_STATS_EN
      check("drop_count", drop_count, m_dcnt);
      check("frame_count", frame_count, m_fcnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] d);
    sample = d;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int i;
    i = 0;
    while (log_d.size() < n && i < budget) begin
      step();
      i++;
    end
    check(nm, log_d.size() >= n, 1);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [15:0] d,
                         input logic c, input logic l);
    if (log_d.size() > idx) begin
      check({nm, "_data"}, log_d[idx], d);
      check({nm, "_ch"}, log_c[idx], c);
      check({nm, "_last"}, log_l[idx], l);
    end else begin
      check({nm, "_present"}, 0, 1);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    check({nm, "_data"}, rd_data, 0);
    check({nm, "_ch"}, rd_ch, 0);
    check({nm, "_valid"}, rd_valid, 0);
    check({nm, "_last"}, rd_last, 0);
    check({nm, "_bufrdy"}, buffer_ready, 0);
    check({nm, "_ovf"}, overflow, 0);
    check({nm, "_sticky"}, overflow_sticky, 0);
  endtask

  int base, br_base, ov_base, md_base, stall;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_zero_outputs("reset");

    // Single bank: A000..A007 out in order with alternating channel tags.
    rd_ready = 1'b1;
    base = log_d.size(); br_base = br_cnt; ov_base = ov_cnt;
    for (int k = 0; k < 8; k++) send(16'hA000 + 16'(k));
    wait_log(base + 8, 80, "s1_timeout");
    idle(3);
    for (int k = 0; k < 8; k++) chk_log("s1", base + k, 16'hA000 + 16'(k), 1'(k % 2), k == 7);
    check("s1_bufrdy_pulses", br_cnt - br_base, 1);
    check("s1_ovf_pulses", ov_cnt - ov_base, 0);

    // Overflow: stalled reader, 24 samples, the last 8 are dropped.
    rd_ready = 1'b0;
    base = log_d.size(); ov_base = ov_cnt; md_base = m_drop_total;
    for (int k = 1; k <= 24; k++) send(16'h1000 + 16'(k));
    idle(2);
    check("s2_ovf_pulses", ov_cnt - ov_base, 8);
    check("s2_model_drops", m_drop_total - md_base, 8);
    check("s2_sticky", overflow_sticky, 1);
`ifdef PINGPONG_MC_STATS_EN
    check("s2_drop_count", drop_count, 8);
`endif
    rd_ready = 1'b1;
    wait_log(base + 16, 120, "s2_timeout");
    chk_log("s2_first", base, 16'h1001, 1'b0, 1'b0);
    chk_log("s2_w8", base + 7, 16'h1008, 1'b1, 1'b1);
    chk_log("s2_w9", base + 8, 16'h1009, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("s2_sticky_cleared", overflow_sticky, 0);
`ifdef PINGPONG_MC_STATS_EN
    check("s2_drop_count_cleared", drop_count, 0);
`endif
    idle(4);

    // Reader released mid-frame while full: swap lands with in_ch=1, so resync to channel 0.
    rd_ready = 1'b0;
    base = log_d.size(); ov_base = ov_cnt;
    for (int k = 1; k <= 16; k++) send(16'h2000 + 16'(k));
    send(16'h20FF);
    idle(2);
    rd_ready = 1'b1;
    wait_log(base + 8, 60, "s3_drain_timeout");
    idle(2);
    send(16'h21FF);
    for (int k = 0; k < 8; k++) send(16'hC000 + 16'(k));
    wait_log(base + 24, 120, "s3_timeout");
    chk_log("s3_resume", base + 16, 16'hC000, 1'b0, 1'b0);
    chk_log("s3_end", base + 23, 16'hC007, 1'b1, 1'b1);
    check("s3_ovf_pulses", ov_cnt - ov_base, 2);
    idle(4);

    // Fill completes on the edge of the final read handshake: no drop, no stall.
    base = log_d.size(); ov_base = ov_cnt; br_base = br_cnt;
    for (int i = 0; i < 32; i++) begin
      sample_valid = (i < 8) || (i >= 16);
      sample = 16'h3000 + 16'(i);
      step();
    end
    sample_valid = 1'b0;
    wait_log(base + 24, 120, "s4_timeout");
    idle(3);
    check("s4_ovf_pulses", ov_cnt - ov_base, 0);
    check("s4_bufrdy_pulses", br_cnt - br_base, 3);
    chk_log("s4_second_bank", base + 8, 16'h3010, 1'b0, 1'b0);

    // Asynchronous reset while holding word 3, then a clean bank.
    base = log_d.size();
    for (int k = 0; k < 8; k++) send(16'hD000 + 16'(k));
    wait_log(base + 3, 60, "s5_reach_timeout");
    rd_ready = 1'b0;
    idle(3);
    check("s5_hold_valid", rd_valid, 1);
    check("s5_hold_ch", rd_ch, 1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    step();
    rst = 1'b0;
    rd_ready = 1'b1;
    base = log_d.size();
    for (int k = 0; k < 8; k++) send(16'hE000 + 16'(k));
    wait_log(base + 8, 80, "s5_timeout");
    chk_log("s5_first", base, 16'hE000, 1'b0, 1'b0);
    chk_log("s5_last", base + 7, 16'hE007, 1'b1, 1'b1);
    idle(4);

    // Random traffic with bursty read stalls and occasional clears.
    stall = 0;
    for (int i = 0; i < 1500; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample = 16'($urandom);
      if (stall == 0 && $urandom_range(0, 40) == 0) stall = $urandom_range(5, 40);
      rd_ready = (stall == 0) && ($urandom_range(0, 3) != 0);
      if (stall > 0) stall--;
      clear = ($urandom_range(0, 50) == 0);
      step();
    end
    sample_valid = 1'b0;
    clear = 1'b0;
    rd_ready = 1'b1;
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
